// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus transmit sequencer feeding a Uart8 transmitter one frame per byte.
// The head byte stays in the FIFO until its frame is done, so txByte never changes mid-frame.
`timescale 1ns/1ps
module uart_tx_feeder #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_wrEn,
    input  logic [7:0]        i_wrData,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_txEn,
    output logic              o_txStart,
    output logic [7:0]        o_txByte,
    input  logic              i_txBusy,
    input  logic              i_txDone,
    output logic              o_sent
);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr, r_rptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow, r_txEn, r_txStart, r_sent, r_done_q;
    logic [7:0]        r_txByte;

    logic w_full, w_empty, w_doneRise, w_push, w_pop, w_load, w_txStart_nxt;

    assign w_full     = (r_count == (ADDR_W+1)'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_doneRise = i_txDone & ~r_done_q;
    // A pop in the same edge frees a slot, so a push into a full FIFO still lands.
    assign w_push     = i_wrEn & (~w_full | w_pop);

    always_comb begin
        w_state_nxt   = r_state;
        w_txStart_nxt = 1'b0;
        w_load        = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_enable && !w_empty && !i_txBusy) begin
                    w_state_nxt   = START;
                    w_txStart_nxt = 1'b1;
                    w_load        = 1'b1;
                end
            end
            START: begin
                // txBusy wins over a simultaneous enable drop: the frame has begun.
                if (i_txBusy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (!i_enable) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_txStart_nxt = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (w_doneRise) begin
                    w_pop       = 1'b1;
                    w_state_nxt = GAP;
                end
            end
            GAP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_txEn     <= 1'b0;
            r_txStart  <= 1'b0;
            r_txByte   <= 8'h00;
            r_sent     <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_txEn     <= i_enable;
            r_txStart  <= w_txStart_nxt;
            r_sent     <= w_pop;
            r_done_q   <= i_txDone;
            r_overflow <= i_wrEn & w_full & ~w_pop;
            if (w_load) r_txByte <= r_mem[r_rptr];
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_push) r_mem[r_wptr] <= i_wrData;
    end

    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_txEn     = r_txEn;
    assign o_txStart  = r_txStart;
    assign o_txByte   = r_txByte;
    assign o_sent     = r_sent;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a short-frame Uart8 stand-in plus a byte scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_feeder;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int FRAME = 12;

    logic clk = 1'b0, reset = 1'b1, enable = 1'b0, wrEn = 1'b0;
    logic [7:0] wrData = 8'h00;
    logic full, empty, overflow, txEn, txStart, sent, txBusy, txDone;
    logic [AW:0] count;
    logic [7:0] txByte;

    int tests = 0, fails = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_wrEn(wrEn), .i_wrData(wrData),
        .o_full(full), .o_empty(empty), .o_count(count), .o_overflow(overflow),
        .o_txEn(txEn), .o_txStart(txStart), .o_txByte(txByte),
        .i_txBusy(txBusy), .i_txDone(txDone), .o_sent(sent)
    );

    // Uart8 stand-in: never reset by the DUT, so an orphan frame runs to completion.
    int m_cnt = 0, stab_err = 0, gap_err = 0, low_run = 0;
    logic m_done = 1'b0, m_valid = 1'b0, seen = 1'b0;
    logic [7:0] m_byte = 8'h00, m_last = 8'h00;
    assign txBusy = (m_cnt != 0);
    assign txDone = m_done;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_valid && !reset && txByte !== m_byte) stab_err <= stab_err + 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_last <= m_byte;
            end
        end else if (txEn && txStart) begin
            m_cnt   <= FRAME;
            m_byte  <= txByte;
            m_valid <= 1'b1;
        end
        if (reset) m_valid <= 1'b0;
        if (txStart) begin
            if (seen && low_run > 0 && low_run < 2) gap_err <= gap_err + 1;
            low_run <= 0;
            seen    <= 1'b1;
        end else begin
            low_run <= low_run + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_sent(output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = 8'h00;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sent === 1'b1) begin
                b  = m_last;
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; wrEn = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        tests++;
        if ({empty, full, overflow, sent, txStart, txEn} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_flags: got %b want 100000", {empty, full, overflow, sent, txStart, txEn});
        end
        tests++;
        if (count !== '0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        tests++;
        if (txByte !== 8'h00) begin fails++; $display("FAIL reset_txbyte: got %h want 00", txByte); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] got, exp;
        bit ok;
        enable = 1'b1;
        repeat (2) tick();
        wrEn = 1'b1; wrData = 8'h7A; sb.push_back(8'h7A);
        tick();
        wrEn = 1'b0;
        @(negedge clk);
        tests++;
        if (count !== 1 || txStart !== 1'b0) begin
            fails++; $display("FAIL single_after_push: count %0d txStart %b want 1 0", count, txStart);
        end
        tick();
        @(negedge clk);
        tests++;
        if (txStart !== 1'b1 || txByte !== 8'h7A) begin
            fails++; $display("FAIL single_start: txStart %b txByte %h want 1 7a", txStart, txByte);
        end
        tick();
        wait_sent(got, ok);
        exp = sb.pop_front();
        tests++;
        if (!ok || got !== exp) begin fails++; $display("FAIL single_byte: got %h (ok %0d) want %h", got, ok, exp); end
        @(negedge clk);
        tests++;
        if (empty !== 1'b1 || stab_err != 0) begin
            fails++; $display("FAIL single_end: empty %b stab_err %0d want 1 0", empty, stab_err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [4] = '{8'h7A, 8'hB1, 8'h00, 8'hFF};
        logic [7:0] got, exp;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            wrEn = 1'b1; wrData = vals[i];
            if (!full) sb.push_back(vals[i]);
            tick();
        end
        wrEn = 1'b0;
        @(negedge clk);
        tests++;
        if (count !== 4) begin fails++; $display("FAIL b2b_count4: got %0d want 4", count); end
        tick();
        for (int i = 0; i < 4; i++) begin
            wait_sent(got, ok);
            exp = sb.pop_front();
            tests++;
            if (!ok || got !== exp) begin fails++; $display("FAIL b2b_byte%0d: got %h (ok %0d) want %h", i, got, ok, exp); end
        end
        tick();
        @(negedge clk);
        tests++;
        if (count !== 0 || gap_err != 0 || stab_err != 0) begin
            fails++; $display("FAIL b2b_end: count %0d gap_err %0d stab_err %0d want 0 0 0", count, gap_err, stab_err);
        end
        tick();
    endtask

    task automatic test_full();
        logic [7:0] got, exp;
        bit ok, hit;
        enable = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            wrEn = 1'b1; wrData = 8'(8'hA0 + i);
            if (!full) sb.push_back(wrData);
            tick();
            if (i == 3) begin
                @(negedge clk);
                tests++;
                if (full !== 1'b1 || overflow !== 1'b0) begin
                    fails++; $display("FAIL full_after4: full %b overflow %b want 1 0", full, overflow);
                end
            end
        end
        wrEn = 1'b0;
        @(negedge clk);
        tests++;
        if (overflow !== 1'b1 || count !== 4) begin
            fails++; $display("FAIL full_overflow: overflow %b count %0d want 1 4", overflow, count);
        end
        tick();
        @(negedge clk);
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL full_ovf_pulse: overflow %b want 0", overflow); end
        tick();
        enable = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txDone === 1'b1) begin hit = 1'b1; break; end
        end
        tests++;
        if (!hit) begin
            fails++; $display("FAIL full_done_timeout: no txDone seen want one");
        end else begin
            wrEn = 1'b1; wrData = 8'hC5; sb.push_back(8'hC5);
            tick();
            wrEn = 1'b0;
            @(negedge clk);
            got = m_last;
            exp = sb.pop_front();
            tests++;
            if (overflow !== 1'b0 || count !== 4 || sent !== 1'b1 || got !== exp) begin
                fails++;
                $display("FAIL full_push_pop: ovf %b count %0d sent %b byte %h want 0 4 1 %h", overflow, count, sent, got, exp);
            end
            tick();
            for (int i = 0; i < 4; i++) begin
                wait_sent(got, ok);
                exp = sb.pop_front();
                tests++;
                if (!ok || got !== exp) begin fails++; $display("FAIL full_drain%0d: got %h (ok %0d) want %h", i, got, ok, exp); end
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_enable_drop();
        logic [7:0] got, exp;
        bit ok, hit;
        int starts;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wrEn = 1'b1; wrData = 8'(8'hD1 + i);
            if (!full) sb.push_back(wrData);
            tick();
        end
        wrEn = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txBusy === 1'b1) begin hit = 1'b1; break; end
        end
        tick();
        repeat (3) tick();
        enable = 1'b0;
        wait_sent(got, ok);
        exp = sb.pop_front();
        tests++;
        if (!hit || !ok || got !== exp) begin
            fails++; $display("FAIL endrop_first: got %h (busy %0d ok %0d) want %h", got, hit, ok, exp);
        end
        starts = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (txStart === 1'b1) starts++;
            tick();
        end
        tests++;
        if (starts != 0 || count !== 2) begin
            fails++; $display("FAIL endrop_hold: txStart cycles %0d count %0d want 0 2", starts, count);
        end
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_sent(got, ok);
            exp = sb.pop_front();
            tests++;
            if (!ok || got !== exp) begin fails++; $display("FAIL endrop_rest%0d: got %h (ok %0d) want %h", i, got, ok, exp); end
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] got, exp;
        int bad, sents;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wrEn = 1'b1; wrData = (i == 0) ? 8'h55 : 8'(i);
            if (!full) sb.push_back(wrData);
            tick();
        end
        wrEn = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txBusy === 1'b1) break;
        end
        tick();
        repeat (FRAME / 2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        tests++;
        if (count !== 0 || txStart !== 1'b0 || empty !== 1'b1) begin
            fails++; $display("FAIL rstmid_clear: count %0d txStart %b empty %b want 0 0 1", count, txStart, empty);
        end
        tick();
        wrEn = 1'b1; wrData = 8'h77; sb.push_back(8'h77);
        tick();
        wrEn = 1'b0;
        bad = 0; sents = 0; got = 8'h00;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txStart === 1'b1 && txBusy === 1'b1 && m_valid === 1'b0) bad++;
            if (sent === 1'b1) begin sents++; got = m_last; end
            tick();
        end
        exp = sb.pop_front();
        tests++;
        if (bad != 0) begin fails++; $display("FAIL rstmid_busy_block: txStart during orphan %0d want 0", bad); end
        tests++;
        if (sents != 1 || got !== exp) begin
            fails++; $display("FAIL rstmid_sent: sent pulses %0d byte %h want 1 %h", sents, got, exp);
        end
        tests++;
        if (count !== 0 || stab_err != 0) begin
            fails++; $display("FAIL rstmid_end: count %0d stab_err %0d want 0 0", count, stab_err);
        end
    endtask

    task automatic test_wrap();
        localparam int N = 3 * DEPTH + 1;
        logic [7:0] got, exp;
        int pushed, retired;
        pushed = 0; retired = 0;
        enable = 1'b1;
        for (int c = 0; c < 1000 && retired < N; c++) begin
            if (pushed < N && !full) begin
                wrEn = 1'b1; wrData = 8'(8'h30 + pushed);
                sb.push_back(wrData);
                pushed++;
            end else begin
                wrEn = 1'b0;
            end
            @(negedge clk);
            if (sent === 1'b1) begin
                got = m_last;
                exp = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
                tests++;
                if (got !== exp) begin fails++; $display("FAIL wrap_byte%0d: got %h want %h", retired, got, exp); end
                retired++;
            end
            tick();
        end
        wrEn = 1'b0;
        tests++;
        if (retired != N || sb.size() != 0 || gap_err != 0) begin
            fails++; $display("FAIL wrap_total: retired %0d left %0d gap_err %0d want %0d 0 0", retired, sb.size(), gap_err, N);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_enable_drop();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
